somador_serial: RTL and testbench

SOMADOR_SERIAL -- requirements
Module: somador_serial

---
 rtl/somador_pkg.sv | 15 +
 rtl/somador_digito.sv | 31 +++
 rtl/somador_serial.sv | 154 +++++++++++++++
 tb/tb_somador_serial.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices that make up a WIDTH-bit operand.
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/somador_digito.sv
// DIGIT-bit combinational ripple-carry slice.
// c_msb is the carry going into the slice's top bit; when this slice holds the
// operand MSB, c_msb ^ cout is the signed overflow flag.
module somador_digito #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] carry;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    s        = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[DIGIT];
  assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/somador_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice
// first, and presents a registered WIDTH-bit result with carry and overflow.
module somador_serial
  import somador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] sliceS;
  logic             sliceCout;
  logic             sliceCmsb;
  logic             lastDigit;
  logic [WIDTH-1:0] sumShift;

  somador_digito #(
    .DIGIT(DIGIT)
  ) u_digito (
    .a    (opA_q[DIGIT-1:0]),
    .b    (opB_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (sliceS),
    .cout (sliceCout),
    .c_msb(sliceCmsb)
  );

  assign lastDigit = (cnt_q == CW'(N - 1));
  // The accumulated sum is shifted right and each new slice enters at the top,
  // so after N slices the full result sits in place.
  assign sumShift  = (sum_q >> DIGIT) | (WIDTH'(sliceS) << (WIDTH - DIGIT));

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts exactly N cycles, DONE exactly one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastDigit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded purely from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: capture on accept, consume one slice per RUN cycle,
  // and load the visible result on the final slice.
  always_comb begin
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = a;
          opB_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        opA_d   = opA_q >> DIGIT;
        opB_d   = opB_q >> DIGIT;
        sum_d   = sumShift;
        carry_d = sliceCout;
        cnt_d   = cnt_q + 1'b1;
        if (lastDigit) begin
          s_d    = sumShift;
          cout_d = sliceCout;
          ovf_d  = sliceCout ^ sliceCmsb;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_somador_serial.sv
// Scoreboard bench for somador_serial with three instances:
// index 0 uses DIGIT=4, index 1 DIGIT=1, index 2 DIGIT=16 (all WIDTH=16).
module tb_somador_serial;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic        cinIn;
  logic        subIn;
  logic        startV [3];
  logic        busyV  [3];
  logic        doneV  [3];
  logic [15:0] sV     [3];
  logic        coutV  [3];
  logic        ovfV   [3];

  int checks;
  int failures;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  somador_serial #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .a(aIn), .b(bIn),
    .cin(cinIn), .sub(subIn), .busy(busyV[0]), .done(doneV[0]),
    .s(sV[0]), .cout(coutV[0]), .ovf(ovfV[0])
  );

  somador_serial #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .a(aIn), .b(bIn),
    .cin(cinIn), .sub(subIn), .busy(busyV[1]), .done(doneV[1]),
    .s(sV[1]), .cout(coutV[1]), .ovf(ovfV[1])
  );

  somador_serial #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(startV[2]), .a(aIn), .b(bIn),
    .cin(cinIn), .sub(subIn), .busy(busyV[2]), .done(doneV[2]),
    .s(sV[2]), .cout(coutV[2]), .ovf(ovfV[2])
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic popExp(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Monitor: whenever an instance pulses done, compare its result against
  // the oldest expectation queued for it; a done with nothing queued is an error.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    for (int d = 0; d < 3; d++) begin
      if (doneV[d] === 1'b1) begin
        popExp(d, e, ok);
        if (!ok) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done dut=%0d actual=done required=no_done", d);
        end else begin
          checkOutput($sformatf("s_dut%0d", d), 32'(sV[d]), 32'(e.s));
          checkOutput($sformatf("cout_dut%0d", d), 32'(coutV[d]), 32'(e.cout));
          checkOutput($sformatf("ovf_dut%0d", d), 32'(ovfV[d]), 32'(e.ovf));
          checkOutput($sformatf("busy_with_done_dut%0d", d), 32'(busyV[d]), 32'd0);
        end
      end
    end
  end

  // Issue one operation on instance d (called at a negedge with d idle).
  // Latency counts the accept edge as edge 1; inputs are scrambled right
  // after the accept edge to confirm the operands were captured.
  task automatic applyStimulus(input int d, input logic [15:0] av, input logic [15:0] bv,
                               input logic ci, input logic sb, input logic [15:0] es,
                               input logic ec, input logic eo, input int expLat,
                               input int expBusy);
    int   lat;
    int   busyCnt;
    exp_t e;
    aIn       = av;
    bIn       = bv;
    cinIn     = ci;
    subIn     = sb;
    startV[d] = 1'b1;
    e.s = es; e.cout = ec; e.ovf = eo;
    pushExp(d, e);
    @(posedge clk);
    #1;
    startV[d] = 1'b0;
    aIn       = 16'hDEAD;
    bIn       = 16'hBEEF;
    cinIn     = ~ci;
    subIn     = ~sb;
    lat       = 1;
    busyCnt   = (busyV[d] === 1'b1) ? 1 : 0;
    while (doneV[d] !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (busyV[d] === 1'b1) busyCnt++;
    end
    checkOutput($sformatf("latency_dut%0d", d), 32'(lat), 32'(expLat));
    checkOutput($sformatf("busy_cycles_dut%0d", d), 32'(busyCnt), 32'(expBusy));
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    aIn       = '0;
    bIn       = '0;
    cinIn     = 1'b0;
    subIn     = 1'b0;
    for (int i = 0; i < 3; i++) startV[i] = 1'b0;

    // Reset state
    #2;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_busy_dut%0d", d), 32'(busyV[d]), 32'd0);
      checkOutput($sformatf("reset_done_dut%0d", d), 32'(doneV[d]), 32'd0);
      checkOutput($sformatf("reset_s_dut%0d", d), 32'(sV[d]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Additions and subtractions on the DIGIT=4 instance
    applyStimulus(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 5, 4);
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 4);
    applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 4);
    applyStimulus(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 5, 4);
    applyStimulus(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 5, 4);
    applyStimulus(0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 5, 4);

    // start held high: one operation per IDLE visit, captured operands only
    aIn = 16'h0001; bIn = 16'h0002; cinIn = 1'b0; subIn = 1'b0;
    pushExp(0, '{s: 16'h0003, cout: 1'b0, ovf: 1'b0});
    pushExp(0, '{s: 16'h3333, cout: 1'b0, ovf: 1'b0});
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    aIn = 16'h1111; bIn = 16'h2222;
    repeat (6) @(posedge clk);
    #1;
    aIn = 16'hAAAA; bIn = 16'h5555;
    cnt = 0;
    while (doneV[0] !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("held_start_second_done", 32'(doneV[0]), 32'd1);
    startV[0] = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the second RUN cycle discards the operation
    applyStimulus(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 5, 4);
    aIn = 16'h4321; bIn = 16'h1111; cinIn = 1'b0; subIn = 1'b0;
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_s", 32'(sV[0]), 32'd0);
    checkOutput("midrun_reset_busy", 32'(busyV[0]), 32'd0);
    checkOutput("midrun_reset_done", 32'(doneV[0]), 32'd0);
    checkOutput("midrun_reset_cout_ovf", {30'd0, coutV[0], ovfV[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 4);

    // Same vectors on DIGIT=1 and DIGIT=16 instances
    applyStimulus(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 17, 16);
    applyStimulus(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 17, 16);
    applyStimulus(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 17, 16);
    applyStimulus(1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 17, 16);
    applyStimulus(2, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 2, 1);
    applyStimulus(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2, 1);
    applyStimulus(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 2, 1);
    applyStimulus(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 2, 1);

    // Results hold after done, and every expectation was consumed
    repeat (4) @(negedge clk);
    checkOutput("hold_s_dut2", 32'(sV[2]), 32'h0000FFFE);
    checkOutput("pending_dut0", 32'(q0.size()), 32'd0);
    checkOutput("pending_dut1", 32'(q1.size()), 32'd0);
    checkOutput("pending_dut2", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
